// File: rtl/mips16_pkg.sv
// Shared encodings for the 16-bit MIPS control logic: opcodes, FSM states,
// datapath mux selects and the control-word payload.
package mips16_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned STATE_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SLI  = 3'b001;
  localparam logic [OP_W-1:0] OP_J    = 3'b010;
  localparam logic [OP_W-1:0] OP_JAL  = 3'b011;
  localparam logic [OP_W-1:0] OP_LW   = 3'b100;
  localparam logic [OP_W-1:0] OP_SW   = 3'b101;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'b110;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_SLT  = 2'b10;
  localparam logic [1:0] ALU_ADDI = 2'b11;

  localparam logic [1:0] PC_PLUS2  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_R7 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  typedef struct packed {
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       sign_or_zero;
  } ctrl_t;

endpackage

// File: rtl/mc_sequencer_if.sv
// Shared single-port memory handshake between the sequencer and memory.
interface mc_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mc_mem_watchdog.sv
// Counts consecutive stalled memory cycles and flags a sticky timeout.
module mc_mem_watchdog #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  input  logic state_chg,
  output logic timeout_c,
  output logic mem_err
);

  localparam int unsigned WAIT_W = 8;

  logic [WAIT_W-1:0] wait_cnt;

  // The stall that would make the count reach WAIT_MAX is the timeout cycle;
  // a ready on that same cycle suppresses it.
  assign timeout_c = req && !ready && (wait_cnt == WAIT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (timeout_c) mem_err <= 1'b1;
      if (!req || ready || state_chg || timeout_c) wait_cnt <= '0;
      else                                         wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 16-bit MIPS
// datapath, sharing one memory port between instruction and data access.
module mc_sequencer
  import mips16_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OP_W-1:0]     opcode,
  input  logic                alu_zero,
  mc_sequencer_if.master      mem,
  output logic                ir_write,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                sign_or_zero,
  output logic [STATE_W-1:0]  state_o,
  output logic [CNT_W-1:0]    instr_cnt,
  output logic                mem_err
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q;
  ctrl_t           ctrl;
  logic            req_c, retire_c, op_load_c, timeout_c, state_chg_c;

  // Request depends only on state, so the watchdog can see it without a loop.
  assign req_c = !reset && (((state_q == ST_FETCH) && run) || (state_q == ST_MEM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      op_q      <= '0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (op_load_c) op_q      <= opcode;
      if (retire_c)  instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d           = state_q;
    retire_c          = 1'b0;
    op_load_c         = 1'b0;
    ctrl              = '0;
    ctrl.sign_or_zero = 1'b1;
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          if (run) begin
            if (mem.mem_ready) begin
              ctrl.ir_write  = 1'b1;
              ctrl.pc_en     = 1'b1;
              ctrl.pc_src    = PC_PLUS2;
              ctrl.alu_src_b = SRCB_TWO;
              ctrl.alu_op    = ALU_ADD;
              state_d        = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          op_load_c      = 1'b1;
          ctrl.alu_src_b = SRCB_IMM_SH;
          ctrl.alu_op    = ALU_ADD;
          state_d        = ST_EXEC;
        end
        ST_EXEC: begin
          case (op_q)
            OP_ADD: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = SRCB_REGB;
              ctrl.alu_op    = ALU_ADD;
              state_d        = ST_WB;
            end
            OP_SLI: begin
              ctrl.alu_src_a    = 1'b1;
              ctrl.alu_src_b    = SRCB_IMM;
              ctrl.alu_op       = ALU_SLT;
              ctrl.sign_or_zero = 1'b0;
              state_d           = ST_WB;
            end
            OP_ADDI: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = SRCB_IMM;
              ctrl.alu_op    = ALU_ADDI;
              state_d        = ST_WB;
            end
            OP_LW, OP_SW: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = SRCB_IMM;
              ctrl.alu_op    = ALU_ADDI;
              state_d        = ST_MEM;
            end
            OP_BEQ: begin
              ctrl.alu_src_a = 1'b1;
              ctrl.alu_src_b = SRCB_REGB;
              ctrl.alu_op    = ALU_SUB;
              ctrl.pc_src    = PC_BRANCH;
              ctrl.pc_en     = alu_zero;
              retire_c       = 1'b1;
              state_d        = ST_FETCH;
            end
            OP_J: begin
              ctrl.pc_en  = 1'b1;
              ctrl.pc_src = PC_JUMP;
              retire_c    = 1'b1;
              state_d     = ST_FETCH;
            end
            OP_JAL: begin
              // PC already holds PC+2 from FETCH, which is the link value.
              ctrl.pc_en      = 1'b1;
              ctrl.pc_src     = PC_JUMP;
              ctrl.reg_write  = 1'b1;
              ctrl.reg_dst    = DST_R7;
              ctrl.mem_to_reg = M2R_PC;
              retire_c        = 1'b1;
              state_d         = ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          ctrl.iord   = 1'b1;
          ctrl.mem_we = (op_q == OP_SW);
          if (mem.mem_ready) begin
            if (op_q == OP_LW) begin
              state_d = ST_WB;
            end else begin
              retire_c = 1'b1;
              state_d  = ST_FETCH;
            end
          end else if (timeout_c) begin
            state_d = ST_FETCH;
          end
        end
        ST_WB: begin
          ctrl.reg_write    = 1'b1;
          ctrl.reg_dst      = (op_q == OP_ADD) ? DST_RD : DST_RT;
          ctrl.mem_to_reg   = (op_q == OP_LW) ? M2R_MDR : M2R_ALU;
          ctrl.sign_or_zero = (op_q != OP_SLI);
          retire_c          = 1'b1;
          state_d           = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  assign state_chg_c = (state_d != state_q);

  mc_mem_watchdog #(.WAIT_MAX(WAIT_MAX)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .req       (req_c),
    .ready     (mem.mem_ready),
    .state_chg (state_chg_c),
    .timeout_c (timeout_c),
    .mem_err   (mem_err)
  );

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = ctrl.mem_we;
  assign mem.iord      = ctrl.iord;
  assign ir_write      = ctrl.ir_write;
  assign pc_en         = ctrl.pc_en;
  assign pc_src        = ctrl.pc_src;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign sign_or_zero  = ctrl.sign_or_zero;
  assign state_o       = reset ? STATE_W'(ST_FETCH) : state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed per-cycle stimulus for mc_sequencer; expected control words are
// queued by the driver and checked by an independent negedge monitor.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, alu_zero;
  logic [2:0]  opcode;
  logic        ir_write, pc_en, alu_src_a, reg_write, sign_or_zero, mem_err;
  logic [1:0]  pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic [2:0]  state_o;
  logic [15:0] instr_cnt;

  mc_sequencer_if bus ();

  mc_sequencer #(.CNT_W(16), .WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem(bus.master), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .sign_or_zero(sign_or_zero), .state_o(state_o), .instr_cnt(instr_cnt),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Field order: req we iord irw pc_en pc_src src_a src_b alu_op rw reg_dst m2r soz
  localparam logic [17:0] IDLE       = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] FETCH_WAIT = {1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,2'b00,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] DEC        = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,2'b00,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] EX_ADD     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b00,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] EX_SLI     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b10,1'b0,2'b00,2'b00,1'b0};
  localparam logic [17:0] EX_IMM     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b11,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] EX_BEQ1    = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] EX_BEQ0    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,2'b01,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] EX_J       = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] EX_JAL     = {1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,2'b00,1'b1,2'b10,2'b10,1'b1};
  localparam logic [17:0] MEM_LW     = {1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] MEM_SW     = {1'b1,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,2'b00,2'b00,1'b1};
  localparam logic [17:0] WB_ADD     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,2'b01,2'b00,1'b1};
  localparam logic [17:0] WB_SLI     = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,2'b00,2'b00,1'b0};
  localparam logic [17:0] WB_ADDI    = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,2'b00,2'b00,1'b1};
  localparam logic [17:0] WB_LW      = {1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,2'b00,2'b01,1'b1};

  typedef struct {
    string       name;
    logic [17:0] ctrl;
    logic [2:0]  st;
    logic [15:0] cnt;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic [15:0] e_cnt;
  logic        e_err;
  logic [17:0] act_ctrl;

  assign act_ctrl = {bus.mem_req, bus.mem_we, bus.iord, ir_write, pc_en, pc_src,
                     alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                     sign_or_zero};

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", what, act, exp);
    else             n_pass++;
  endtask

  // One clock cycle: queue what this cycle must show, then advance.
  task automatic t(input string nm, input logic rdy, input logic [17:0] ec, input logic [2:0] es);
    exp_t e;
    bus.mem_ready = rdy;
    e.name = nm; e.ctrl = ec; e.st = es; e.cnt = e_cnt; e.err = e_err;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".ctrl"},  32'(act_ctrl),  32'(e.ctrl));
      check({e.name, ".state"}, 32'(state_o),   32'(e.st));
      check({e.name, ".cnt"},   32'(instr_cnt), 32'(e.cnt));
      check({e.name, ".err"},   32'(mem_err),   32'(e.err));
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 3'b000; alu_zero = 1'b0; bus.mem_ready = 1'b0;
    e_cnt = 16'd0; e_err = 1'b0;
    @(posedge clk); #1;
    t("rst", 0, IDLE, 3'd0);

    // Reset held two cycles while an lw is waiting in MEM
    reset = 1'b0; run = 1'b1; opcode = 3'b100;
    t("f_lw_a", 1, FETCH_RDY, 3'd0);
    t("d_lw_a", 1, DEC, 3'd1);
    t("e_lw_a", 1, EX_IMM, 3'd2);
    t("m_lw_a", 0, MEM_LW, 3'd3);
    reset = 1'b1;
    t("rst_mem1", 0, IDLE, 3'd0);
    t("rst_mem2", 0, IDLE, 3'd0);
    reset = 1'b0;

    // add, sli, addi with zero-wait memory; run dropped during addi EXEC
    opcode = 3'b000;
    t("f_add", 1, FETCH_RDY, 3'd0); t("d_add", 1, DEC, 3'd1);
    t("e_add", 1, EX_ADD, 3'd2);    t("wb_add", 1, WB_ADD, 3'd4);
    e_cnt = 16'd1; opcode = 3'b001;
    t("f_sli", 1, FETCH_RDY, 3'd0); t("d_sli", 1, DEC, 3'd1);
    t("e_sli", 1, EX_SLI, 3'd2);    t("wb_sli", 1, WB_SLI, 3'd4);
    e_cnt = 16'd2; opcode = 3'b111;
    t("f_addi", 1, FETCH_RDY, 3'd0); t("d_addi", 1, DEC, 3'd1);
    run = 1'b0;
    t("e_addi", 1, EX_IMM, 3'd2);    t("wb_addi", 1, WB_ADDI, 3'd4);
    e_cnt = 16'd3;
    t("idle_run0", 1, IDLE, 3'd0);
    run = 1'b1;

    // Fetch stall, then lw with two MEM wait cycles
    opcode = 3'b100;
    t("fw_lw", 0, FETCH_WAIT, 3'd0);
    t("f_lw", 1, FETCH_RDY, 3'd0); t("d_lw", 1, DEC, 3'd1);
    t("e_lw", 1, EX_IMM, 3'd2);
    t("m_lw_w1", 0, MEM_LW, 3'd3); t("m_lw_w2", 0, MEM_LW, 3'd3);
    t("m_lw_rdy", 1, MEM_LW, 3'd3);
    t("wb_lw", 1, WB_LW, 3'd4);
    e_cnt = 16'd4;

    // beq taken and not taken
    opcode = 3'b110; alu_zero = 1'b1;
    t("f_beq1", 1, FETCH_RDY, 3'd0); t("d_beq1", 1, DEC, 3'd1);
    t("e_beq1", 1, EX_BEQ1, 3'd2);
    e_cnt = 16'd5; alu_zero = 1'b0;
    t("f_beq0", 1, FETCH_RDY, 3'd0); t("d_beq0", 1, DEC, 3'd1);
    t("e_beq0", 1, EX_BEQ0, 3'd2);
    e_cnt = 16'd6;

    // jal then j
    opcode = 3'b011;
    t("f_jal", 1, FETCH_RDY, 3'd0); t("d_jal", 1, DEC, 3'd1);
    t("e_jal", 1, EX_JAL, 3'd2);
    e_cnt = 16'd7; opcode = 3'b010;
    t("f_j", 1, FETCH_RDY, 3'd0); t("d_j", 1, DEC, 3'd1);
    t("e_j", 1, EX_J, 3'd2);
    e_cnt = 16'd8;

    // sw whose memory never answers: 15 stalled MEM cycles then timeout
    opcode = 3'b101;
    t("f_sw", 1, FETCH_RDY, 3'd0); t("d_sw", 1, DEC, 3'd1);
    t("e_sw", 1, EX_IMM, 3'd2);
    for (int i = 0; i < 15; i++) t($sformatf("m_sw_wait%0d", i), 0, MEM_SW, 3'd3);
    e_err = 1'b1;

    // mem_err stays set through a following add
    opcode = 3'b000;
    t("f_add_err", 1, FETCH_RDY, 3'd0); t("d_add_err", 1, DEC, 3'd1);
    t("e_add_err", 1, EX_ADD, 3'd2);    t("wb_add_err", 1, WB_ADD, 3'd4);
    e_cnt = 16'd9; run = 1'b0;
    t("idle_err", 0, IDLE, 3'd0);

    // Final reset clears counter and sticky error
    reset = 1'b1;
    t("rst_end1", 0, IDLE, 3'd0);
    e_cnt = 16'd0; e_err = 1'b0;
    t("rst_end2", 0, IDLE, 3'd0);
    reset = 1'b0;
    t("idle_end", 0, IDLE, 3'd0);

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
